seq_tx: RTL and testbench
=========================

// Module: seq_tx
// PURPOSE
//  Serial pattern transmitter; the driving end of the sequence-detector interface.
//  Latches a WIDTH-bit pattern on a start handshake, then shifts it out LSB-first on
//  serial line `a`, one bit per clk. Repeats the pattern back-to-back a programmable
//  number of times. Feeds seqDetect-style receivers directly, in place of bench-only stimulus.
// PARAMETERS
//  WIDTH    4   pattern length in bits (>=2)
//  RPT_W    8   width of repeat-count input
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  reset       in   1        asynchronous, active-high reset
//  pattern     in   WIDTH    pattern to send; bit 0 transmitted first
//  repeat_cnt  in   RPT_W    extra repetitions (0 -> sent once, N -> N+1 times)
//  start       in   1        request; accepted only when ready=1
//  abort       in   1        synchronous abort of an in-progress transfer
//  ready       out  1        idle, able to accept start
//  a           out  1        serial data out
//  a_valid     out  1        a carries a pattern bit this cycle
//  frame       out  1        high with the first bit of every repetition
//  done        out  1        one-cycle pulse after the final bit
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. While reset=1: state IDLE,
//    ready=1, a=0, a_valid=0, frame=0, done=0, shift reg/counters cleared.
//  - All outputs registered. States: IDLE, SHIFT, DONE.
//  - IDLE: ready=1. start=1 at edge -> latch pattern into shift reg, repeat_cnt into rpt,
//    bit_idx=0, go SHIFT. start while ready=0 is ignored (not queued).
//  - Latency: start sampled at edge k -> first bit on a, a_valid=1, frame=1 after edge k.
//  - SHIFT: a=pattern_latched[bit_idx], a_valid=1, frame=(bit_idx==0). Each edge
//    bit_idx++. At bit_idx==WIDTH-1: if rpt!=0 -> rpt--, bit_idx wraps to 0 (no gap
//    cycle, next repetition starts the very next cycle); else go DONE.
//  - DONE: one cycle; done=1, a_valid=0, a=0, ready=0; next edge -> IDLE.
//  - ready is low from the cycle after start acceptance through DONE; high again the
//    cycle done falls. Fastest restart: start asserted in the first IDLE cycle.
//  - abort=1 in SHIFT: next edge -> IDLE directly; a_valid=0, a=0, no done pulse.
//    abort in IDLE/DONE ignored. abort and start same cycle in IDLE: start wins.
//  - pattern/repeat_cnt changes after acceptance have no effect on the transfer.
//  - Total SHIFT cycles per transfer = WIDTH*(repeat_cnt+1); rpt max 2**RPT_W-1.
//  - bit_idx width $clog2(WIDTH); compare against WIDTH-1, never rely on natural wrap.
//  - reset asserted mid-transfer: immediate return to reset values, transfer lost.
// STRUCTURE
//  - seq_pkg: typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_t; default
//    SEQ_WIDTH=4 localparam shared with the detector and benches.
//  - One sub-module natural: seq_bit_ctr (bit_idx + repeat counter, emits last_bit,
//    last_rep). FSM and output regs stay in seq_tx.
// TESTING
//  1 reset held 3 cycles, release -> ready=1, a=0, a_valid=0, done=0 throughout.
//  2 pattern=4'b0100, repeat_cnt=0, start 1 cycle -> a = 0,0,1,0 on next 4 cycles,
//    frame only on first, done pulse cycle 5, ready=1 cycle 6.
//  3 pattern=4'b1011, repeat_cnt=2 -> 12 contiguous a_valid cycles, a=1,1,0,1 x3,
//    frame on cycles 1,5,9; single done; loopback into seqDetect gives valid per frame.
//  4 abort on 2nd bit of pattern=4'b0110 -> a_valid low next cycle, no done, ready=1.
//  5 start held high continuously, repeat_cnt=0 -> back-to-back transfers, each with
//    one DONE cycle gap; start during SHIFT ignored; new pattern value sampled per start.
//  6 reset asserted asynchronously mid-SHIFT (between edges) -> outputs zero
//    immediately, ready=1; next start transmits cleanly from bit 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial sequence transmitter/detector pair.
package seq_pkg;

  localparam int SEQ_WIDTH = 4;
  localparam int SEQ_RPT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/seq_bit_ctr.sv
// Bit-index and repetition counter for seq_tx; exposes next-index so the
// transmitter can register its outputs in the same cycle the index moves.
module seq_bit_ctr #(
  parameter  int WIDTH = 4,
  parameter  int RPT_W = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [RPT_W-1:0] rpt_init,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             last_bit,
  output logic             last_rep
);

  logic [IDX_W-1:0] bit_idx;
  logic [RPT_W-1:0] rpt, rpt_nxt;

  // Explicit compare so non-power-of-two widths wrap at WIDTH-1.
  assign last_bit = (bit_idx == IDX_W'(WIDTH - 1));
  assign last_rep = (rpt == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    idx_nxt = bit_idx;
    rpt_nxt = rpt;
    if (load) begin
      idx_nxt = '0;
      rpt_nxt = rpt_init;
    end else if (advance) begin
      if (last_bit) begin
        idx_nxt = '0;
        if (!last_rep) rpt_nxt = rpt - 1'b1;
      end else begin
        idx_nxt = bit_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // independent of statement order.
    if (reset) begin
      bit_idx <= '0;
      rpt     <= '0;
    end else begin
      bit_idx <= idx_nxt;
      rpt     <= rpt_nxt;
    end
  end

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: latches a pattern on start and shifts it out
// LSB-first on `a`, repeated back-to-back repeat_cnt+1 times.
module seq_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int RPT_W = SEQ_RPT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pattern,
  input  logic [RPT_W-1:0] repeat_cnt,
  input  logic             start,
  input  logic             abort,
  output logic             ready,
  output logic             a,
  output logic             a_valid,
  output logic             frame,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);

  seq_state_t       state, state_nxt;
  logic [WIDTH-1:0] pat_q, pat_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             load, advance, last_bit, last_rep;

  seq_bit_ctr #(
    .WIDTH(WIDTH),
    .RPT_W(RPT_W)
  ) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .rpt_init(repeat_cnt),
    .idx_nxt (idx_nxt),
    .last_bit(last_bit),
    .last_rep(last_rep)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        // start beats a simultaneous abort here: abort only acts in SHIFT.
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          advance = 1'b1;
          if (last_bit && last_rep) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pat_nxt = load ? pattern : pat_q;

  // Outputs are registered from the next-state view so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      // NOTE: the latched pattern is reset too; it is a single register, not a
      // memory, and a known value keeps `a` deterministic after reset.
      pat_q   <= '0;
      ready   <= 1'b1;
      a       <= 1'b0;
      a_valid <= 1'b0;
      frame   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pat_q   <= pat_nxt;
      ready   <= (state_nxt == IDLE);
      a_valid <= (state_nxt == SHIFT);
      a       <= (state_nxt == SHIFT) && pat_nxt[idx_nxt];
      frame   <= (state_nxt == SHIFT) && (idx_nxt == '0);
      done    <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// Directed, table-driven bench for seq_tx with hand-written multi-cycle sequences
// for maximum repeat count and asynchronous mid-transfer reset.
module tb_seq_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pattern = '0;
  logic [7:0] repeat_cnt = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ready, a, a_valid, frame, done;
  logic [4:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  // outs = {ready, a, a_valid, frame, done}
  localparam logic [4:0] ID_O = 5'b10000;
  localparam logic [4:0] DN_O = 5'b00001;

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] pat;
    logic [7:0] rpt;
    logic [4:0] exp;
  } vec_t;

  vec_t vq[$];

  seq_tx #(.WIDTH(4), .RPT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .pattern   (pattern),
    .repeat_cnt(repeat_cnt),
    .start     (start),
    .abort     (abort),
    .ready     (ready),
    .a         (a),
    .a_valid   (a_valid),
    .frame     (frame),
    .done      (done)
  );

  assign outs = {ready, a, a_valid, frame, done};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [4:0] sh(input logic bit_a, input logic fr);
    return {1'b0, bit_a, 1'b1, fr, 1'b0};
  endfunction

  function automatic void add(input logic s, input logic ab, input logic [3:0] p,
                              input logic [7:0] r, input logic [4:0] e);
    vq.push_back('{start: s, abort: ab, pat: p, rpt: r, exp: e});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] p;
    int         nv, nfr, bad;
    bit         seen_done;

    // Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold%0d", i), outs, ID_O);
    end
    reset = 1'b0;
    tick();
    check("reset_release", outs, ID_O);

    // pattern 0100, sent once
    add(1, 0, 4'b0100, 0, sh(0, 1));
    add(0, 0, 4'b0100, 0, sh(0, 0));
    add(0, 0, 4'b0100, 0, sh(1, 0));
    add(0, 0, 4'b0100, 0, sh(0, 0));
    add(0, 0, 4'b0100, 0, DN_O);
    add(0, 0, 4'b0100, 0, ID_O);
    // pattern 1011, three times; start and input changes mid-transfer ignored
    add(1, 0, 4'b1011, 2, sh(1, 1));
    add(1, 0, 4'b0000, 0, sh(1, 0));
    add(1, 0, 4'b0000, 0, sh(0, 0));
    add(1, 0, 4'b0000, 0, sh(1, 0));
    add(1, 0, 4'b0000, 0, sh(1, 1));
    add(1, 0, 4'b0000, 0, sh(1, 0));
    add(1, 0, 4'b0000, 0, sh(0, 0));
    add(0, 0, 4'b0000, 0, sh(1, 0));
    add(0, 0, 4'b0000, 0, sh(1, 1));
    add(0, 0, 4'b0000, 0, sh(1, 0));
    add(0, 0, 4'b0000, 0, sh(0, 0));
    add(0, 0, 4'b0000, 0, sh(1, 0));
    add(0, 0, 4'b0000, 0, DN_O);
    add(0, 1, 4'b0000, 0, ID_O);
    // start held high: back-to-back transfers, new pattern per acceptance
    add(1, 0, 4'b0110, 0, sh(0, 1));
    add(1, 0, 4'b1001, 0, sh(1, 0));
    add(1, 0, 4'b1001, 0, sh(1, 0));
    add(1, 0, 4'b1001, 0, sh(0, 0));
    add(1, 0, 4'b1001, 0, DN_O);
    add(1, 0, 4'b1001, 0, ID_O);
    add(1, 0, 4'b1001, 0, sh(1, 1));
    add(0, 0, 4'b1001, 0, sh(0, 0));
    add(0, 0, 4'b1001, 0, sh(0, 0));
    add(0, 0, 4'b1001, 0, sh(1, 0));
    add(0, 0, 4'b1001, 0, DN_O);
    add(0, 0, 4'b1001, 0, ID_O);
    // abort on the second bit of 0110: no done pulse
    add(1, 0, 4'b0110, 0, sh(0, 1));
    add(0, 0, 4'b0110, 0, sh(1, 0));
    add(0, 1, 4'b0110, 0, ID_O);
    add(0, 0, 4'b0110, 0, ID_O);
    // start and abort together in IDLE: start wins; abort then kills it
    add(1, 1, 4'b0011, 0, sh(1, 1));
    add(0, 1, 4'b0011, 0, ID_O);
    // one repeat with wrap, abort during DONE ignored
    add(1, 0, 4'b0001, 1, sh(1, 1));
    add(0, 0, 4'b0001, 1, sh(0, 0));
    add(0, 0, 4'b0001, 1, sh(0, 0));
    add(0, 0, 4'b0001, 1, sh(0, 0));
    add(0, 0, 4'b0001, 1, sh(1, 1));
    add(0, 0, 4'b0001, 1, sh(0, 0));
    add(0, 0, 4'b0001, 1, sh(0, 0));
    add(0, 0, 4'b0001, 1, sh(0, 0));
    add(0, 0, 4'b0001, 1, DN_O);
    add(0, 1, 4'b0001, 1, ID_O);

    foreach (vq[i]) begin
      start      = vq[i].start;
      abort      = vq[i].abort;
      pattern    = vq[i].pat;
      repeat_cnt = vq[i].rpt;
      tick();
      check($sformatf("vec%0d", i), outs, vq[i].exp);
    end
    start = 1'b0;
    abort = 1'b0;

    // Maximum repeat count: 256 repetitions, 1024 contiguous bits.
    p          = 4'b1010;
    pattern    = p;
    repeat_cnt = 8'hFF;
    start      = 1'b1;
    tick();
    start     = 1'b0;
    pattern   = 4'b0000;
    nv        = 0;
    nfr       = 0;
    bad       = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 1200 && !seen_done; c++) begin
      if (done) begin
        seen_done = 1'b1;
      end else if (a_valid) begin
        if (a !== p[nv % 4]) bad++;
        if (frame !== (nv % 4 == 0)) bad++;
        if (frame) nfr++;
        nv++;
      end else begin
        bad++;
      end
      tick();
    end
    check("maxrpt_done_seen", 32'(seen_done), 32'd1);
    check("maxrpt_bits", nv, 1024);
    check("maxrpt_frames", nfr, 256);
    check("maxrpt_bad", bad, 0);
    check("maxrpt_idle", outs, ID_O);

    // Asynchronous reset between edges mid-SHIFT.
    pattern    = 4'b1101;
    repeat_cnt = 8'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_reset_shift", outs, sh(0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_now", outs, ID_O);
    tick();
    check("async_reset_held", outs, ID_O);
    reset = 1'b0;
    tick();
    check("post_reset_idle", outs, ID_O);
    pattern    = 4'b0110;
    repeat_cnt = 8'd0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("restart_bit0", outs, sh(0, 1));
    tick();
    check("restart_bit1", outs, sh(1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
